// File: rtl/decode_seq.sv
// Registered one-hot decoder/sequencer: an index register stepped by load/inc/dec
// commands, with its one-hot decode and wrap/saturation status pulses registered alongside.
module decode_seq #(
  parameter int unsigned IN_WIDTH    = 2,
  parameter int unsigned RESET_INDEX = 0,
  parameter int unsigned WRAP        = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [IN_WIDTH-1:0]        in,
  output logic [(1<<IN_WIDTH)-1:0]   out,
  output logic [IN_WIDTH-1:0]        index,
  output logic                       wrapped,
  output logic                       at_limit
);

  localparam int unsigned            OUT_WIDTH = 1 << IN_WIDTH;
  localparam logic [IN_WIDTH-1:0]    MAX_IDX   = '1;
  localparam logic [IN_WIDTH-1:0]    ONE       = IN_WIDTH'(1);
  localparam logic [IN_WIDTH-1:0]    RST_IDX   = IN_WIDTH'(RESET_INDEX);
  localparam logic [OUT_WIDTH-1:0]   RST_OUT   = OUT_WIDTH'(1) << RESET_INDEX;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_INC  = 2'b10;
  localparam logic [1:0] MODE_DEC  = 2'b11;

  logic [IN_WIDTH-1:0]  next_index;
  logic [OUT_WIDTH-1:0] next_out;
  logic                 next_wrapped;
  logic                 next_at_limit;

  always_comb begin
    next_index    = index;
    next_wrapped  = 1'b0;
    next_at_limit = 1'b0;
    if (en) begin
      case (mode)
        MODE_LOAD: next_index = in;
        MODE_INC: begin
          if (index != MAX_IDX) begin
            next_index = index + ONE;
          end else if (WRAP != 0) begin
            next_index   = '0;
            next_wrapped = 1'b1;
          end else begin
            next_at_limit = 1'b1;
          end
        end
        MODE_DEC: begin
          if (index != '0) begin
            next_index = index - ONE;
          end else if (WRAP != 0) begin
            next_index   = MAX_IDX;
            next_wrapped = 1'b1;
          end else begin
            next_at_limit = 1'b1;
          end
        end
        default: next_index = index;
      endcase
    end
  end

  // Decode from next_index so out and index always update on the same edge.
  always_comb begin
    next_out             = '0;
    next_out[next_index] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index    <= RST_IDX;
      out      <= RST_OUT;
      wrapped  <= 1'b0;
      at_limit <= 1'b0;
    end else begin
      index    <= next_index;
      out      <= next_out;
      wrapped  <= next_wrapped;
      at_limit <= next_at_limit;
    end
  end

endmodule

// File: tb/tb_decode_seq.sv
// Bench for decode_seq: directed steps on two configurations, then a random
// command stream on wrapping and saturating 4-bit instances against an arithmetic model.
module tb_decode_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: defaults (IN_WIDTH=2, WRAP=1, RESET_INDEX=0)
  logic       reset_a, en_a;
  logic [1:0] mode_a, in_a, index_a;
  logic [3:0] out_a;
  logic       wrapped_a, at_limit_a;

  decode_seq dut_a (
    .clk(clk), .reset(reset_a), .en(en_a), .mode(mode_a), .in(in_a),
    .out(out_a), .index(index_a), .wrapped(wrapped_a), .at_limit(at_limit_a)
  );

  // Instance B: IN_WIDTH=3, saturating, RESET_INDEX=6
  logic       reset_b, en_b;
  logic [1:0] mode_b;
  logic [2:0] in_b, index_b;
  logic [7:0] out_b;
  logic       wrapped_b, at_limit_b;

  decode_seq #(.IN_WIDTH(3), .RESET_INDEX(6), .WRAP(0)) dut_b (
    .clk(clk), .reset(reset_b), .en(en_b), .mode(mode_b), .in(in_b),
    .out(out_b), .index(index_b), .wrapped(wrapped_b), .at_limit(at_limit_b)
  );

  // Instances C (wrap) and D (saturate): IN_WIDTH=4, shared random stimulus
  logic        reset_r, en_r;
  logic [1:0]  mode_r;
  logic [3:0]  in_r, index_c, index_d;
  logic [15:0] out_c, out_d;
  logic        wrapped_c, at_limit_c, wrapped_d, at_limit_d;

  decode_seq #(.IN_WIDTH(4), .RESET_INDEX(0), .WRAP(1)) dut_c (
    .clk(clk), .reset(reset_r), .en(en_r), .mode(mode_r), .in(in_r),
    .out(out_c), .index(index_c), .wrapped(wrapped_c), .at_limit(at_limit_c)
  );

  decode_seq #(.IN_WIDTH(4), .RESET_INDEX(0), .WRAP(0)) dut_d (
    .clk(clk), .reset(reset_r), .en(en_r), .mode(mode_r), .in(in_r),
    .out(out_d), .index(index_d), .wrapped(wrapped_d), .at_limit(at_limit_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int idx, input bit w);
    chk({tag, ".index"}, 32'(index_a), 32'(idx));
    chk({tag, ".out"}, 32'(out_a), 32'(1) << idx);
    chk({tag, ".wrapped"}, 32'(wrapped_a), 32'(w));
    chk({tag, ".at_limit"}, 32'(at_limit_a), 32'd0);
  endtask

  task automatic chk_b(input string tag, input logic [7:0] o, input bit lim);
    chk({tag, ".out"}, 32'(out_b), 32'(o));
    chk({tag, ".at_limit"}, 32'(at_limit_b), 32'(lim));
    chk({tag, ".wrapped"}, 32'(wrapped_b), 32'd0);
  endtask

  task automatic cmd_a(input bit e, input logic [1:0] m, input logic [1:0] v);
    en_a = e; mode_a = m; in_a = v;
    tick();
  endtask

  task automatic cmd_b(input bit e, input logic [1:0] m, input logic [2:0] v);
    en_b = e; mode_b = m; in_b = v;
    tick();
  endtask

  // Reference: index as a plain integer in 0..n-1, modular or clamped stepping.
  function automatic void ref_step(input bit wrap, input int n, input bit rst, input bit e,
                                   input int m, input int v, inout int idx,
                                   output bit w, output bit lim);
    w = 1'b0; lim = 1'b0;
    if (rst) begin
      idx = 0;
    end else if (e) begin
      if (m == 1) idx = v;
      else if (m == 2) begin
        if (idx + 1 < n) idx = idx + 1;
        else if (wrap) begin idx = (idx + 1) % n; w = 1'b1; end
        else lim = 1'b1;
      end else if (m == 3) begin
        if (idx - 1 >= 0) idx = idx - 1;
        else if (wrap) begin idx = (idx - 1 + n) % n; w = 1'b1; end
        else lim = 1'b1;
      end
    end
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mc, md;
    bit wc, lc, wd, ld;
    reset_a = 1'b1; en_a = 1'b0; mode_a = 2'b00; in_a = 2'd0;
    reset_b = 1'b1; en_b = 1'b0; mode_b = 2'b00; in_b = 3'd0;
    reset_r = 1'b1; en_r = 1'b0; mode_r = 2'b00; in_r = 4'd0;

    // --- instance A: reset, loads
    tick(); tick();
    chk_a("a_reset", 0, 1'b0);
    reset_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_a(1'b1, 2'b01, 2'(i));
      chk_a($sformatf("a_load%0d", i), i, 1'b0);
    end

    // load 2, inc x3, dec x2
    cmd_a(1'b1, 2'b01, 2'd2);
    cmd_a(1'b1, 2'b10, 2'd0); chk_a("a_inc1", 3, 1'b0);
    cmd_a(1'b1, 2'b10, 2'd0); chk_a("a_inc2_wrap", 0, 1'b1);
    cmd_a(1'b1, 2'b10, 2'd0); chk_a("a_inc3", 1, 1'b0);
    cmd_a(1'b1, 2'b11, 2'd0); chk_a("a_dec1", 0, 1'b0);
    cmd_a(1'b1, 2'b11, 2'd0); chk_a("a_dec2_wrap", 3, 1'b1);

    // back-to-back wraps keep the pulse high
    cmd_a(1'b1, 2'b10, 2'd0); chk_a("a_b2b_inc", 0, 1'b1);
    cmd_a(1'b1, 2'b11, 2'd0); chk_a("a_b2b_dec", 3, 1'b1);

    // en=0 holds regardless of mode
    cmd_a(1'b1, 2'b01, 2'd1);
    for (int i = 0; i < 5; i++) begin
      cmd_a(1'b0, 2'b10, 2'd3);
      chk_a($sformatf("a_hold%0d", i), 1, 1'b0);
    end

    // reset wins over a wrapping inc
    cmd_a(1'b1, 2'b01, 2'd3);
    chk_a("a_pre_rst", 3, 1'b0);
    reset_a = 1'b1;
    cmd_a(1'b1, 2'b10, 2'd0);
    chk_a("a_rst_over_wrap", 0, 1'b0);
    reset_a = 1'b0;

    // --- instance B: saturation
    chk_b("b_reset", 8'h40, 1'b0);
    chk("b_reset.index", 32'(index_b), 32'd6);
    reset_b = 1'b0;
    cmd_b(1'b1, 2'b10, 3'd0); chk_b("b_inc1", 8'h80, 1'b0);
    cmd_b(1'b1, 2'b10, 3'd0); chk_b("b_inc2_sat", 8'h80, 1'b1);
    cmd_b(1'b1, 2'b10, 3'd0); chk_b("b_inc3_sat", 8'h80, 1'b1);
    cmd_b(1'b1, 2'b01, 3'd0); chk_b("b_load0", 8'h01, 1'b0);
    cmd_b(1'b1, 2'b11, 3'd0); chk_b("b_dec_sat", 8'h01, 1'b1);
    cmd_b(1'b0, 2'b11, 3'd0); chk_b("b_pulse_clear", 8'h01, 1'b0);

    // --- instances C/D: random stream against the model
    mc = 0; md = 0;
    for (int c = 0; c < 1000; c++) begin
      reset_r = (c == 0) || ($urandom_range(0, 49) == 0);
      en_r    = ($urandom_range(0, 7) != 0);
      mode_r  = 2'($urandom_range(0, 3));
      in_r    = 4'($urandom_range(0, 15));
      ref_step(1'b1, 16, reset_r, en_r, int'(mode_r), int'(in_r), mc, wc, lc);
      ref_step(1'b0, 16, reset_r, en_r, int'(mode_r), int'(in_r), md, wd, ld);
      tick();
      chk("c.index", 32'(index_c), 32'(mc));
      chk("c.out", 32'(out_c), 32'(1) << mc);
      chk("c.wrapped", 32'(wrapped_c), 32'(wc));
      chk("c.at_limit", 32'(at_limit_c), 32'(lc));
      chk("d.index", 32'(index_d), 32'(md));
      chk("d.out", 32'(out_d), 32'(1) << md);
      chk("d.wrapped", 32'(wrapped_d), 32'(wd));
      chk("d.at_limit", 32'(at_limit_d), 32'(ld));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
